fp_mult_pipe: RTL and testbench

Parametrised, pipelined floating-point multiplier for the custom sign/exponent/fraction format used across the arithmetic blocks: 1 sign bit, ES exponent bits, N-1-ES fraction bits. It generalises the fixed 24-bit combinational multiplier: width and exponent split are parameters, rounding mode is selectable per operation, exception flags are produced, and a valid/ready handshake with full backpressure makes it usable inside streaming datapaths. Latency is three cycles and throughput is one result per cycle.

---
 rtl/fp_mult_pipe.sv | 126 ++++++++++++
 tb/tb_fp_mult_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: three-stage sign/exponent/fraction multiplier with per-operation rounding mode,
// exception flags and a valid/ready handshake with full backpressure.
module fp_mult_pipe #(
    parameter int N  = 24,
    parameter int ES = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         rnd_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] r,
    output logic [2:0]   flags
);
    localparam int M  = N - 1 - ES;
    localparam int EW = ES + 2;
    localparam logic signed [EW-1:0] BIAS = EW'(2 ** (ES - 1) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'(2 ** ES - 1);
    localparam logic [ES-1:0] EONES = '1;
    localparam logic [N-1:0] QNAN = {1'b0, EONES, 1'b1, {(M-1){1'b0}}};

    logic v1, v2, en1, en2, en3;
    logic [ES-1:0] ea, eb;
    logic [M-1:0] fa, fb;
    logic sgn, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, nan_any, inv, sp_c;
    logic [N-1:0] spr_c;
    logic [2:0] spf_c;
    logic [2*M+1:0] p_c;
    logic signed [EW-1:0] e_c;
    logic rm1, sp1, s1;
    logic [N-1:0] spr1;
    logic [2:0] spf1;
    logic signed [EW-1:0] e1;
    logic [2*M+1:0] p1;
    logic [2*M:0] pn;
    logic rm2, sp2, s2, g2, st2;
    logic [N-1:0] spr2;
    logic [2:0] spf2;
    logic signed [EW-1:0] e2, e3;
    logic [M-1:0] f2;
    logic inc, ovf, unf;
    logic [M:0] fr;
    logic [N-1:0] r_c;
    logic [2:0] f_c;

    // a stage may load when empty or when its contents leave in the same cycle
    assign en3 = ~out_valid | out_ready;
    assign en2 = ~v2 | en3;
    assign en1 = ~v1 | en2;
    assign in_ready = en1;

    assign ea = a[N-2:M];
    assign eb = b[N-2:M];
    assign fa = a[M-1:0];
    assign fb = b[M-1:0];
    assign sgn = a[N-1] ^ b[N-1];
    assign nan_a = (&ea) & (|fa);
    assign nan_b = (&eb) & (|fb);
    assign inf_a = (&ea) & ~(|fa);
    assign inf_b = (&eb) & ~(|fb);
    assign zero_a = ~(|ea);
    assign zero_b = ~(|eb);
    assign nan_any = nan_a | nan_b;
    assign inv = ~nan_any & ((zero_a & inf_b) | (inf_a & zero_b));
    assign sp_c = nan_any | inf_a | inf_b | zero_a | zero_b;
    assign spr_c = (nan_any | inv) ? QNAN : (inf_a | inf_b) ? {sgn, EONES, {M{1'b0}}} : {sgn, {(N-1){1'b0}}};
    assign spf_c = {inv, 2'b00};
    assign p_c = (2*M+2)'({1'b1, fa}) * (2*M+2)'({1'b1, fb});
    assign e_c = EW'(ea) + EW'(eb) - BIAS;

    assign pn = p1[2*M+1] ? p1[2*M:0] : {p1[2*M-1:0], 1'b0};

    assign inc = ~rm2 & g2 & (st2 | f2[0]);
    assign fr = {1'b0, f2} + (M+1)'(inc);
    assign e3 = e2 + EW'(fr[M]);
    assign ovf = e3 >= EMAX;
    assign unf = e3[EW-1] | ~(|e3);
    assign r_c = sp2 ? spr2 : ovf ? {s2, EONES, {M{1'b0}}} : unf ? {s2, {(N-1){1'b0}}} : {s2, e3[ES-1:0], fr[M-1:0]};
    assign f_c = sp2 ? spf2 : {1'b0, ovf, unf};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            out_valid <= 1'b0;
            r <= '0;
            flags <= '0;
        end else begin
            if (en1) v1 <= in_valid;
            if (en2) v2 <= v1;
            if (en3) begin
                out_valid <= v2;
                r <= r_c;
                flags <= f_c;
            end
        end
    end

    // datapath registers carry no reset; their valid bits qualify them
    always_ff @(posedge clk) begin
        if (en1) begin
            rm1 <= rnd_mode;
            sp1 <= sp_c;
            spr1 <= spr_c;
            spf1 <= spf_c;
            s1 <= sgn;
            e1 <= e_c;
            p1 <= p_c;
        end
        if (en2) begin
            rm2 <= rm1;
            sp2 <= sp1;
            spr2 <= spr1;
            spf2 <= spf1;
            s2 <= s1;
            e2 <= e1 + EW'(p1[2*M+1]);
            f2 <= pn[2*M:M+1];
            g2 <= pn[M];
            st2 <= |pn[M-1:0];
        end
    end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: scoreboard bench for fp_mult_pipe with a real-arithmetic reference model.
module tb_fp_mult_pipe;
    localparam int N  = 24;
    localparam int ES = 6;

    logic clk = 0, rst = 1, in_valid = 0, rnd_mode = 0, out_ready = 1;
    logic in_ready, out_valid;
    logic [N-1:0] a = '0, b = '0, r;
    logic [2:0] flags;
    int checks = 0, errors = 0, acc = 0;
    bit rand_on = 0;
    logic [N+2:0] q[$];

    always #5 clk = ~clk;

    fp_mult_pipe #(.N(N), .ES(ES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .rnd_mode(rnd_mode), .out_valid(out_valid), .out_ready(out_ready), .r(r), .flags(flags)
    );

    // value-level model: exact real product, then rounded to 17 fraction bits
    function automatic logic [N+2:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input logic rm);
        int ex, ey, fx, fy, e, fl, be;
        real m, qv, rem;
        logic s;
        ex = int'(x[22:17]);
        ey = int'(y[22:17]);
        fx = int'(x[16:0]);
        fy = int'(y[16:0]);
        s = x[23] ^ y[23];
        if ((ex == 63 && fx != 0) || (ey == 63 && fy != 0)) return {3'b000, 24'h7F0000};
        if ((ex == 0 && ey == 63) || (ex == 63 && ey == 0)) return {3'b100, 24'h7F0000};
        if (ex == 63 || ey == 63) return {3'b000, s, 6'h3F, 17'h0};
        if (ex == 0 || ey == 0) return {3'b000, s, 23'h0};
        m = (1.0 + fx / 131072.0) * (1.0 + fy / 131072.0);
        e = ex + ey - 62;
        if (m >= 2.0) begin
            m = m / 2.0;
            e++;
        end
        qv = m * 131072.0;
        fl = $rtoi(qv);
        rem = qv - fl;
        if (!rm && (rem > 0.5 || (rem == 0.5 && fl % 2 == 1))) fl++;
        if (fl == 262144) begin
            fl = 131072;
            e++;
        end
        be = e + 31;
        if (be >= 63) return {3'b010, s, 6'h3F, 17'h0};
        if (be <= 0) return {3'b001, s, 23'h0};
        return {3'b000, s, 6'(be), 17'(fl)};
    endfunction

    function automatic logic [N-1:0] rop();
        int k;
        logic [5:0] e;
        logic [16:0] f;
        k = $urandom_range(0, 11);
        e = (k == 0) ? 6'd0 : (k == 1) ? 6'd63 : (k < 5) ? 6'($urandom_range(1, 62)) : 6'($urandom_range(18, 44));
        f = ($urandom_range(0, 7) == 0) ? 17'h0 : 17'($urandom_range(0, 131071));
        return {1'($urandom_range(0, 1)), e, f};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got r=%h flags=%b expected no output", r, flags);
            end else begin
                if ({flags, r} !== q[0]) begin
                    errors++;
                    $display("FAIL result got r=%h flags=%b expected r=%h flags=%b", r, flags, q[0][N-1:0], q[0][N+2:N]);
                end
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic rm, input logic [N+2:0] e);
        int t;
        a = x;
        b = y;
        rnd_mode = rm;
        in_valid = 1;
        for (t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (t == 1000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got in_ready=0 expected 1");
        end else begin
            q.push_back(e);
            acc++;
        end
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic rsend();
        logic [N-1:0] x, y;
        logic rm;
        x = rop();
        y = rop();
        rm = 1'($urandom_range(0, 1));
        send(x, y, rm, model(x, y, rm));
    endtask

    task automatic lat_send(input logic [N-1:0] x, input logic [N-1:0] y, input logic [N+2:0] e);
        int lat;
        send(x, y, 1'b0, e);
        for (lat = 1; lat < 20; lat++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
        end
        chk("latency", 32'(lat), 32'd3);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && q.size() != 0; t++) @(posedge clk);
        #1 chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    logic [N-1:0] da[8] = '{24'h3F0000, 24'h3E0001, 24'h3E0001, 24'h7C0000, 24'h020000, 24'h000000, 24'h800000, 24'h7E0001};
    logic [N-1:0] db[8] = '{24'h3F0000, 24'h3F0000, 24'h3F0000, 24'h400000, 24'h020000, 24'h7E0000, 24'h3E0000, 24'h3E0000};
    logic         dm[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [N+2:0] de[8] = '{{3'b000, 24'h404000}, {3'b000, 24'h3F0002}, {3'b000, 24'h3F0001}, {3'b010, 24'h7E0000},
                            {3'b001, 24'h000000}, {3'b100, 24'h7F0000}, {3'b000, 24'h800000}, {3'b000, 24'h7F0000}};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_r", 32'(r), 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        rst = 0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        lat_send(24'h3E0000, 24'h400000, {3'b000, 24'h400000});
        for (int i = 0; i < 8; i++) send(da[i], db[i], dm[i], de[i]);
        drain();

        acc = 0;
        fork
            for (int i = 0; i < 8; i++) rsend();
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 0;
                @(negedge clk);
                chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                chk("bp_accepts_at_full", 32'(acc), 32'd3);
                repeat (5) @(posedge clk);
                @(negedge clk);
                chk("bp_accepts_during_stall", 32'(acc), 32'd3);
                @(posedge clk);
                #1 out_ready = 1;
            end
        join
        drain();
        chk("bp_total_accepts", 32'(acc), 32'd8);

        rand_on = 1;
        fork
            begin
                repeat (300) begin
                    rsend();
                    repeat ($urandom_range(0, 1)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rand_on = 0;
            end
            while (rand_on) begin
                @(posedge clk);
                #1 out_ready = ($urandom_range(0, 3) != 0);
            end
        join
        out_ready = 1;
        drain();

        send(rop(), rop(), 1'b0, 27'h0);
        send(rop(), rop(), 1'b0, 27'h0);
        #2 rst = 1;
        q.delete();
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        repeat (5) @(posedge clk);
        #1 chk("after_reset_idle", 32'(out_valid), 32'd0);
        lat_send(24'h3F0000, 24'h3F0000, {3'b000, 24'h404000});
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
